// File: rtl/vga_sram_arb_pkg.sv
// vga_sram_arb_pkg
// Shared types for the VGA SRAM arbiter slice.
//   arb_state_t : last command issued to the SRAM (drives write-to-read turnaround)
//   owner_t     : which requester a read belongs to
//   tag_t       : one slot of the read-return tag pipe
package vga_sram_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR
    } arb_state_t;

    typedef enum logic {
        OWN_DISP,
        OWN_SRC
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;

    localparam tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_DISP};

endpackage

// File: rtl/vga_sram_rd_tag_pipe.sv
// vga_sram_rd_tag_pipe
// Fixed-depth shift register of read tags. A tag pushed in the grant cycle
// emerges on tag_out exactly DEPTH cycles later, lined up with the SRAM data.
// Ports:
//   sys_clk, sys_rst : clock, asynchronous active-high reset (flushes all tags)
//   tag_in           : tag pushed this cycle (valid=0 on non-read cycles)
//   tag_out          : oldest tag in the pipe
module vga_sram_rd_tag_pipe
    import vga_sram_arb_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stages [DEPTH];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= TAG_NONE;
            end
        end else begin
            stages[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/vga_sram_arbiter.sv
// vga_sram_arbiter
// Shares one SRAM Avalon-MM port between the display prefetch reader and the
// source (pixel writer / host) port. One grant per cycle at most; the granted
// command is registered onto the SRAM port and read data is routed back to
// its owner with a one-cycle readdatavalid pulse.
// Ports:
//   sys_clk, sys_rst      : clock, asynchronous active-high reset
//   disp_avn_*            : display read-only master (read, address, waitrequest,
//                           readdata, readdatavalid)
//   src_avn_*             : source read/write master (read, write, address,
//                           writedata, byteenable, waitrequest, readdata,
//                           readdatavalid)
//   sram_avn_*            : registered command to the SRAM controller and its
//                           returning readdata
module vga_sram_arbiter
    import vga_sram_arb_pkg::*;
#(
    parameter int AVN_AW       = 18,
    parameter int AVN_DW       = 16,
    parameter int SRAM_RD_LAT  = 2,
    parameter int SRC_MAX_WAIT = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst,

    input  logic                disp_avn_read,
    input  logic [AVN_AW-1:0]   disp_avn_address,
    output logic                disp_avn_waitrequest,
    output logic [AVN_DW-1:0]   disp_avn_readdata,
    output logic                disp_avn_readdatavalid,

    input  logic                src_avn_read,
    input  logic                src_avn_write,
    input  logic [AVN_AW-1:0]   src_avn_address,
    input  logic [AVN_DW-1:0]   src_avn_writedata,
    input  logic [AVN_DW/8-1:0] src_avn_byteenable,
    output logic                src_avn_waitrequest,
    output logic [AVN_DW-1:0]   src_avn_readdata,
    output logic                src_avn_readdatavalid,

    output logic                sram_avn_read,
    output logic                sram_avn_write,
    output logic [AVN_AW-1:0]   sram_avn_address,
    output logic [AVN_DW-1:0]   sram_avn_writedata,
    output logic [AVN_DW/8-1:0] sram_avn_byteenable,
    input  logic [AVN_DW-1:0]   sram_avn_readdata
);

    localparam int               BE_W     = AVN_DW / 8;
    localparam int               CNT_W    = $clog2(SRC_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SRC_MAX_WAIT);
    localparam int               TAG_DEPTH = SRAM_RD_LAT + 1;

    arb_state_t        state;
    arb_state_t        state_next;
    logic [CNT_W-1:0]  starve_cnt;

    logic              src_req;
    logic              src_is_wr;
    logic              disp_legal;
    logic              src_legal;
    logic              force_src;
    logic              grant_disp;
    logic              grant_src;
    logic              grant_rd;
    logic              grant_wr;

    tag_t              tag_in;
    tag_t              tag_out;

    // Grant selection and next state. A source read+write is treated as a
    // write. After a write (S_WR) reads are held off one cycle so the async
    // SRAM gets its turnaround bubble; back-to-back writes are still allowed.
    // Nothing is granted while reset is high, which also forces both
    // waitrequests high.
    always_comb begin
        src_req    = src_avn_read | src_avn_write;
        src_is_wr  = src_avn_write;
        disp_legal = (state != S_WR);
        src_legal  = src_is_wr || (state != S_WR);
        force_src  = (starve_cnt == CNT_MAX) && src_req && src_legal;
        grant_disp = 1'b0;
        grant_src  = 1'b0;

        if (!sys_rst) begin
            if (force_src) begin
                grant_src = 1'b1;
            end else if (disp_avn_read && disp_legal) begin
                grant_disp = 1'b1;
            end else if (src_req && src_legal) begin
                grant_src = 1'b1;
            end
        end

        grant_rd = grant_disp || (grant_src && !src_is_wr);
        grant_wr = grant_src && src_is_wr;

        if (grant_wr) begin
            state_next = S_WR;
        end else if (grant_rd) begin
            state_next = S_RD;
        end else begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counts consecutive denied source cycles; saturates at SRC_MAX_WAIT where
    // it forces the next legal source request through ahead of the display.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            starve_cnt <= '0;
        end else if (!src_req || grant_src) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Registered SRAM command: strobes last exactly one cycle, the payload
    // fields hold between commands. Display reads use full byte enables.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sram_avn_read       <= 1'b0;
            sram_avn_write      <= 1'b0;
            sram_avn_address    <= '0;
            sram_avn_writedata  <= '0;
            sram_avn_byteenable <= '0;
        end else begin
            sram_avn_read  <= grant_rd;
            sram_avn_write <= grant_wr;
            if (grant_src) begin
                sram_avn_address    <= src_avn_address;
                sram_avn_writedata  <= src_avn_writedata;
                sram_avn_byteenable <= src_avn_byteenable;
            end else if (grant_disp) begin
                sram_avn_address    <= disp_avn_address;
                sram_avn_writedata  <= '0;
                sram_avn_byteenable <= {BE_W{1'b1}};
            end
        end
    end

    assign tag_in = '{valid: grant_rd, owner: (grant_src ? OWN_SRC : OWN_DISP)};

    vga_sram_rd_tag_pipe #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_pipe (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // The emerging tag lines up with valid SRAM data; capture it for the
    // owner only, the other owner's readdata keeps its last value.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            disp_avn_readdata      <= '0;
            disp_avn_readdatavalid <= 1'b0;
            src_avn_readdata       <= '0;
            src_avn_readdatavalid  <= 1'b0;
        end else begin
            disp_avn_readdatavalid <= tag_out.valid && (tag_out.owner == OWN_DISP);
            src_avn_readdatavalid  <= tag_out.valid && (tag_out.owner == OWN_SRC);
            if (tag_out.valid && (tag_out.owner == OWN_DISP)) begin
                disp_avn_readdata <= sram_avn_readdata;
            end
            if (tag_out.valid && (tag_out.owner == OWN_SRC)) begin
                src_avn_readdata <= sram_avn_readdata;
            end
        end
    end

    assign disp_avn_waitrequest = !grant_disp;
    assign src_avn_waitrequest  = !grant_src;

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// tb_vga_sram_arbiter
// Directed bench for vga_sram_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for starvation, interleaved returns, mid-flight reset
// and a single display read. A tiny SRAM model returns addr ^ 16'hABDD two
// cycles after each read command.
module tb_vga_sram_arbiter;

    localparam int AW  = 18;
    localparam int DW  = 16;
    localparam int LAT = 2;
    localparam int MAXW = 8;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          disp_avn_read;
    logic [AW-1:0] disp_avn_address;
    logic          disp_avn_waitrequest;
    logic [DW-1:0] disp_avn_readdata;
    logic          disp_avn_readdatavalid;
    logic          src_avn_read;
    logic          src_avn_write;
    logic [AW-1:0] src_avn_address;
    logic [DW-1:0] src_avn_writedata;
    logic [1:0]    src_avn_byteenable;
    logic          src_avn_waitrequest;
    logic [DW-1:0] src_avn_readdata;
    logic          src_avn_readdatavalid;
    logic          sram_avn_read;
    logic          sram_avn_write;
    logic [AW-1:0] sram_avn_address;
    logic [DW-1:0] sram_avn_writedata;
    logic [1:0]    sram_avn_byteenable;
    logic [DW-1:0] sram_avn_readdata;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    vga_sram_arbiter #(
        .AVN_AW       (AW),
        .AVN_DW       (DW),
        .SRAM_RD_LAT  (LAT),
        .SRC_MAX_WAIT (MAXW)
    ) dut (
        .sys_clk                (sys_clk),
        .sys_rst                (sys_rst),
        .disp_avn_read          (disp_avn_read),
        .disp_avn_address       (disp_avn_address),
        .disp_avn_waitrequest   (disp_avn_waitrequest),
        .disp_avn_readdata      (disp_avn_readdata),
        .disp_avn_readdatavalid (disp_avn_readdatavalid),
        .src_avn_read           (src_avn_read),
        .src_avn_write          (src_avn_write),
        .src_avn_address        (src_avn_address),
        .src_avn_writedata      (src_avn_writedata),
        .src_avn_byteenable     (src_avn_byteenable),
        .src_avn_waitrequest    (src_avn_waitrequest),
        .src_avn_readdata       (src_avn_readdata),
        .src_avn_readdatavalid  (src_avn_readdatavalid),
        .sram_avn_read          (sram_avn_read),
        .sram_avn_write         (sram_avn_write),
        .sram_avn_address       (sram_avn_address),
        .sram_avn_writedata     (sram_avn_writedata),
        .sram_avn_byteenable    (sram_avn_byteenable),
        .sram_avn_readdata      (sram_avn_readdata)
    );

    // SRAM model: data valid LAT cycles after the read command cycle.
    logic [1:0]    mrd = 2'b00;
    logic [AW-1:0] madr0;
    logic [AW-1:0] madr1;
    always @(posedge sys_clk) begin
        mrd   <= {mrd[0], sram_avn_read};
        madr0 <= sram_avn_address;
        madr1 <= madr0;
    end
    assign sram_avn_readdata = mrd[1] ? (madr1[15:0] ^ 16'hABDD) : 16'hDEAD;

    typedef struct {
        logic          d_rd;
        logic          s_rd;
        logic          s_wr;
        logic [AW-1:0] d_addr;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_wdata;
        logic [1:0]    s_be;
        logic          e_dwait;
        logic          e_swait;
        logic          e_rd;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [1:0]    e_be;
        logic          e_dval;
        logic          e_sval;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mkv(input bit d_rd, s_rd, s_wr,
                                 input int d_addr, s_addr, s_wdata, s_be,
                                 input bit e_dwait, e_swait, e_rd, e_wr,
                                 input int e_addr, e_wdata, e_be,
                                 input bit e_dval, e_sval,
                                 input int e_rdata);
        vec_t v;
        v.d_rd    = d_rd;
        v.s_rd    = s_rd;
        v.s_wr    = s_wr;
        v.d_addr  = d_addr[AW-1:0];
        v.s_addr  = s_addr[AW-1:0];
        v.s_wdata = s_wdata[DW-1:0];
        v.s_be    = s_be[1:0];
        v.e_dwait = e_dwait;
        v.e_swait = e_swait;
        v.e_rd    = e_rd;
        v.e_wr    = e_wr;
        v.e_addr  = e_addr[AW-1:0];
        v.e_wdata = e_wdata[DW-1:0];
        v.e_be    = e_be[1:0];
        v.e_dval  = e_dval;
        v.e_sval  = e_sval;
        v.e_rdata = e_rdata[DW-1:0];
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        disp_avn_read      = 1'b0;
        disp_avn_address   = '0;
        src_avn_read       = 1'b0;
        src_avn_write      = 1'b0;
        src_avn_address    = '0;
        src_avn_writedata  = '0;
        src_avn_byteenable = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        disp_avn_read      = v.d_rd;
        disp_avn_address   = v.d_addr;
        src_avn_read       = v.s_rd;
        src_avn_write      = v.s_wr;
        src_avn_address    = v.s_addr;
        src_avn_writedata  = v.s_wdata;
        src_avn_byteenable = v.s_be;
    endtask

    // Leaves the bench one time unit after a rising edge with reset released.
    task automatic doReset();
        clearInputs();
        sys_rst = 1'b1;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  waits;
        bit  granted;
        int  pulses;

        //        d_rd s_rd s_wr d_addr s_addr wdata  be  dw sw rd wr e_addr e_wdata e_be dv sv rdata
        tbl[0]  = mkv(0, 0, 0, 0,     0,     0,      0,  1, 1, 0, 0, 0,     0,      0,   0, 0, 0);
        tbl[1]  = mkv(1, 0, 0, 'h10,  0,     0,      0,  0, 1, 0, 0, 0,     0,      0,   0, 0, 0);
        tbl[2]  = mkv(0, 0, 1, 0,     'h20,  'h1234, 3,  1, 0, 1, 0, 'h10,  0,      3,   0, 0, 0);
        tbl[3]  = mkv(1, 0, 0, 'h11,  0,     0,      0,  1, 1, 0, 1, 'h20,  'h1234, 3,   0, 0, 0);
        tbl[4]  = mkv(1, 0, 0, 'h11,  0,     0,      0,  0, 1, 0, 0, 0,     0,      0,   0, 0, 0);
        tbl[5]  = mkv(0, 1, 1, 0,     'h30,  'h5555, 1,  1, 0, 1, 0, 'h11,  0,      3,   1, 0, 'hABCD);
        tbl[6]  = mkv(0, 0, 1, 0,     'h31,  'h6666, 2,  1, 0, 0, 1, 'h30,  'h5555, 1,   0, 0, 0);
        tbl[7]  = mkv(0, 1, 0, 0,     'h32,  0,      3,  1, 1, 0, 1, 'h31,  'h6666, 2,   0, 0, 0);
        tbl[8]  = mkv(0, 1, 0, 0,     'h32,  0,      3,  1, 0, 0, 0, 0,     0,      0,   1, 0, 'hABCC);
        tbl[9]  = mkv(0, 0, 0, 0,     0,     0,      0,  1, 1, 1, 0, 'h32,  0,      3,   0, 0, 0);
        tbl[10] = mkv(0, 0, 0, 0,     0,     0,      0,  1, 1, 0, 0, 0,     0,      0,   0, 0, 0);
        tbl[11] = mkv(0, 0, 0, 0,     0,     0,      0,  1, 1, 0, 0, 0,     0,      0,   0, 0, 0);
        tbl[12] = mkv(0, 0, 0, 0,     0,     0,      0,  1, 1, 0, 0, 0,     0,      0,   0, 1, 'hABEF);

        // Reset state
        clearInputs();
        sys_rst = 1'b1;
        @(negedge sys_clk);
        checkOutput("rst.sram_read",  sram_avn_read, 0);
        checkOutput("rst.sram_write", sram_avn_write, 0);
        checkOutput("rst.sram_addr",  sram_avn_address, 0);
        checkOutput("rst.sram_wdata", sram_avn_writedata, 0);
        checkOutput("rst.sram_be",    sram_avn_byteenable, 0);
        checkOutput("rst.disp_val",   disp_avn_readdatavalid, 0);
        checkOutput("rst.src_val",    src_avn_readdatavalid, 0);
        checkOutput("rst.disp_rdata", disp_avn_readdata, 0);
        checkOutput("rst.src_rdata",  src_avn_readdata, 0);
        checkOutput("rst.disp_wait",  disp_avn_waitrequest, 1);
        checkOutput("rst.src_wait",   src_avn_waitrequest, 1);
        nextCycle();
        sys_rst = 1'b0;

        // Cycle-by-cycle vector table: grants, turnaround, conflict, returns
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i]);
            @(negedge sys_clk);
            checkOutput($sformatf("v%0d.disp_wait", i), disp_avn_waitrequest, tbl[i].e_dwait);
            checkOutput($sformatf("v%0d.src_wait", i), src_avn_waitrequest, tbl[i].e_swait);
            checkOutput($sformatf("v%0d.sram_read", i), sram_avn_read, tbl[i].e_rd);
            checkOutput($sformatf("v%0d.sram_write", i), sram_avn_write, tbl[i].e_wr);
            if (tbl[i].e_rd || tbl[i].e_wr) begin
                checkOutput($sformatf("v%0d.sram_addr", i), sram_avn_address, tbl[i].e_addr);
                checkOutput($sformatf("v%0d.sram_be", i), sram_avn_byteenable, tbl[i].e_be);
            end
            if (tbl[i].e_wr)
                checkOutput($sformatf("v%0d.sram_wdata", i), sram_avn_writedata, tbl[i].e_wdata);
            checkOutput($sformatf("v%0d.disp_val", i), disp_avn_readdatavalid, tbl[i].e_dval);
            checkOutput($sformatf("v%0d.src_val", i), src_avn_readdatavalid, tbl[i].e_sval);
            if (tbl[i].e_dval)
                checkOutput($sformatf("v%0d.disp_rdata", i), disp_avn_readdata, tbl[i].e_rdata);
            if (tbl[i].e_sval)
                checkOutput($sformatf("v%0d.src_rdata", i), src_avn_readdata, tbl[i].e_rdata);
            nextCycle();
        end

        // Starvation: continuous display reads against a pending source write
        doReset();
        disp_avn_read      = 1'b1;
        disp_avn_address   = 18'h00040;
        src_avn_write      = 1'b1;
        src_avn_address    = 18'h00020;
        src_avn_writedata  = 16'h1234;
        src_avn_byteenable = 2'b11;
        waits   = 0;
        granted = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge sys_clk);
            if (!src_avn_waitrequest) begin
                granted = 1'b1;
                checkOutput("starve.disp_wait_on_force", disp_avn_waitrequest, 1);
            end else begin
                waits++;
            end
            nextCycle();
            if (granted) break;
        end
        src_avn_write = 1'b0;
        checkOutput("starve.granted", granted, 1);
        checkOutput("starve.wait_cycles", waits, MAXW);
        @(negedge sys_clk);
        checkOutput("starve.sram_write", sram_avn_write, 1);
        checkOutput("starve.sram_addr", sram_avn_address, 'h20);
        checkOutput("starve.sram_wdata", sram_avn_writedata, 'h1234);
        checkOutput("starve.disp_turnaround_wait", disp_avn_waitrequest, 1);
        nextCycle();
        @(negedge sys_clk);
        checkOutput("starve.disp_resume", disp_avn_waitrequest, 0);
        checkOutput("starve.bubble_rd", sram_avn_read, 0);
        checkOutput("starve.bubble_wr", sram_avn_write, 0);
        nextCycle();
        disp_avn_read = 1'b0;
        @(negedge sys_clk);
        checkOutput("starve.read_after_bubble", sram_avn_read, 1);
        checkOutput("starve.read_addr", sram_avn_address, 'h40);
        nextCycle();

        // Interleaved reads disp@1, src@2, disp@3: in-order, no cross-routing
        doReset();
        for (int c = 0; c < 9; c++) begin
            clearInputs();
            if (c == 0) begin disp_avn_read = 1'b1; disp_avn_address = 18'd1; end
            if (c == 1) begin src_avn_read  = 1'b1; src_avn_address  = 18'd2; src_avn_byteenable = 2'b11; end
            if (c == 2) begin disp_avn_read = 1'b1; disp_avn_address = 18'd3; end
            @(negedge sys_clk);
            if (c == 0 || c == 2)
                checkOutput($sformatf("ilv%0d.disp_wait", c), disp_avn_waitrequest, 0);
            if (c == 1)
                checkOutput($sformatf("ilv%0d.src_wait", c), src_avn_waitrequest, 0);
            if (c >= 3) begin
                checkOutput($sformatf("ilv%0d.disp_val", c), disp_avn_readdatavalid, (c == 4 || c == 6));
                checkOutput($sformatf("ilv%0d.src_val", c), src_avn_readdatavalid, (c == 5));
            end
            if (c == 4) checkOutput("ilv4.disp_rdata", disp_avn_readdata, 'hABDC);
            if (c == 5) begin
                checkOutput("ilv5.src_rdata", src_avn_readdata, 'hABDF);
                checkOutput("ilv5.disp_hold", disp_avn_readdata, 'hABDC);
            end
            if (c == 6) begin
                checkOutput("ilv6.disp_rdata", disp_avn_readdata, 'hABDE);
                checkOutput("ilv6.src_hold", src_avn_readdata, 'hABDF);
            end
            nextCycle();
        end

        // Async reset with two reads in flight
        doReset();
        disp_avn_read    = 1'b1;
        disp_avn_address = 18'd5;
        nextCycle();
        disp_avn_read      = 1'b0;
        src_avn_read       = 1'b1;
        src_avn_address    = 18'd6;
        src_avn_byteenable = 2'b11;
        nextCycle();
        clearInputs();
        #2;
        disp_avn_read = 1'b1;
        sys_rst = 1'b1;
        #1;
        checkOutput("arst.sram_read", sram_avn_read, 0);
        checkOutput("arst.sram_addr", sram_avn_address, 0);
        checkOutput("arst.sram_be", sram_avn_byteenable, 0);
        checkOutput("arst.disp_wait", disp_avn_waitrequest, 1);
        checkOutput("arst.src_wait", src_avn_waitrequest, 1);
        checkOutput("arst.disp_val", disp_avn_readdatavalid, 0);
        checkOutput("arst.src_val", src_avn_readdatavalid, 0);
        disp_avn_read = 1'b0;
        nextCycle();
        sys_rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge sys_clk);
            pulses += int'(disp_avn_readdatavalid) + int'(src_avn_readdatavalid);
            nextCycle();
        end
        checkOutput("arst.dropped_returns", pulses, 0);

        // Single display read after reset: command at +1, data at +4
        disp_avn_read    = 1'b1;
        disp_avn_address = 18'h00010;
        @(negedge sys_clk);
        checkOutput("single.disp_wait", disp_avn_waitrequest, 0);
        nextCycle();
        disp_avn_read = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge sys_clk);
            checkOutput($sformatf("single%0d.sram_read", k), sram_avn_read, (k == 1));
            if (k == 1) begin
                checkOutput("single1.sram_addr", sram_avn_address, 'h10);
                checkOutput("single1.sram_be", sram_avn_byteenable, 'h3);
            end
            checkOutput($sformatf("single%0d.disp_val", k), disp_avn_readdatavalid, (k == 4));
            checkOutput($sformatf("single%0d.src_val", k), src_avn_readdatavalid, 0);
            if (k == 4) checkOutput("single4.disp_rdata", disp_avn_readdata, 'hABCD);
            nextCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
